bsg_priority_issue_queue: RTL and testbench
===========================================

# bsg_priority_issue_queue

Stateful front-end for the codebase's priority encoder. It accumulates one-bit service requests in a pending bitmask and priority-encodes that mask each cycle. It issues one registered index at a time on a valid/yumi interface and retires each issued bit from the mask. It sits between request sources (interrupt lines, per-entry ready flags, replay bits) and a single consumer that serves one index per cycle.

## Interface
- `width_p`, default 32: number of request bits; any value ≥ 1.
- `lo_to_hi_p`, default 0: 0 gives the highest index priority; 1 gives the lowest index priority.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_n_i`, input, 1: reset, asynchronous, active-low.
- `set_v_i`, input, 1: qualifies `set_i`.
- `set_i`, input, `width_p`: bits to OR into the pending mask.
- `clr_all_i`, input, 1: flush the pending mask and the output register.
- `v_o`, output, 1: `addr_o` holds a valid issued index.
- `addr_o`, output, `$clog2(width_p)` (minimum 1): issued index.
- `yumi_i`, input, 1: consumer takes `addr_o` this cycle. Legal only when `v_o` = 1.
- `pending_o`, output, `width_p`: current pending mask, excluding the in-flight index.
- `empty_o`, output, 1: equals `~v_o & ~|pending_o`.

## Operation
- State:
  - `pending_r` (`width_p` bits).
  - Output register `v_r`/`addr_r`.
- Combinational encode of `pending_r` by the selected priority gives `sel_oh` (one-hot), `sel_addr`, and `sel_v`.
- `load = (~v_r | yumi_i) & sel_v & ~clr_all_i`.
- Next-state, in priority order:
  1. If `clr_all_i`: `pending_r` ← 0 and `v_r` ← 0. `set_i` is ignored and `yumi_i` has no further effect.
  2. Else:
     - `pending_r` ← `(pending_r & ~(load ? sel_oh : 0)) | (set_v_i ? set_i : 0)`.
     - If `load`: `v_r` ← 1 and `addr_r` ← `sel_addr`.
     - Else if `yumi_i`: `v_r` ← 0.
     - Else hold.
- A bit is removed from `pending_r` when it is loaded into the output register, not when it is consumed. The in-flight index is therefore never issued twice.
- A set of a bit that is in flight, or that is being loaded in the same cycle, re-arms that bit. It is issued again later as a new event.
- A set of a bit that is already pending merges with it. No counting, no overflow.
- When `yumi_i` = 0 and `v_r` = 1, `addr_r` holds and new sets only accumulate.
- `yumi_i` while `v_o` = 0 is a protocol error. It is flagged by an assertion, and the RTL ignores it.

## Timing
- Reset (asynchronous assert, synchronous release): `pending_r` = 0, `v_o` = 0, `addr_o` = 0, `pending_o` = 0, `empty_o` = 1.
- Reset asserted mid-operation drops the in-flight index and all pending bits immediately. No issue occurs until the first edge after release.
- Latency:
  - `set_v_i` at cycle N → bit in `pending_o` at N+1 → `v_o` at N+2, provided the output register is free or yumi'd in N+1.
- Throughput: with `yumi_i` held high, one index is issued per cycle, in strict priority order as re-evaluated every cycle.
  - A higher-priority bit set at cycle N preempts only indices not yet loaded. It is loaded at N+1 at the earliest.
- `v_o` and `addr_o` come directly from flops; there is no combinational path from inputs to outputs.
- `pending_o` comes from a flop.

## Structure
- A shared package is not required. Derive `lg_width_lp = $clog2(width_p)` locally, with a minimum of 1.
- The single sub-module is `bsg_priority_encode` (`width_p`, `lo_to_hi_p`), driven by `pending_r` and supplying `sel_addr`/`sel_v`.
  - `sel_oh` is derived by decoding `sel_addr` with `bsg_decode`.
- Place the assertion for `yumi_i & ~v_o` in a non-synthesis block.

## Test plan
- Reset/idle:
  - `reset_n_i` low for 3 cycles → `v_o` = 0, `addr_o` = 0, `pending_o` = 0, `empty_o` = 1.
  - After release with no stimulus, outputs are unchanged.
- Priority drain:
  - `set_i` = 0x8000_0011 for one cycle with `yumi_i` = 1 throughout, `lo_to_hi_p` = 0.
  - → `addr_o` = 31, 4, 0 on consecutive cycles starting at N+2, then `v_o` = 0.
  - Same stimulus with `lo_to_hi_p` = 1 → 0, 4, 31.
- Backpressure:
  - Set 0x0000_0006 with `yumi_i` = 0 → `v_o` = 1 and `addr_o` = 2 held.
  - `pending_o` = 0x0000_0002 while held.
  - Sets of 0x0000_0100 while held only change `pending_o` to 0x0000_0102.
  - Next `yumi_i` → `addr_o` = 8.
- Re-arm in flight:
  - With `addr_o` = 5 held, set bit 5 → `pending_o` shows bit 5.
  - After yumi, `addr_o` = 5 again, then `v_o` = 0.
- Flush:
  - With `v_o` = 1 and pending 0xFF00, assert `clr_all_i` together with `set_i` = 0x1 → next cycle `v_o` = 0, `pending_o` = 0, `empty_o` = 1.
- Async reset mid-stream:
  - Pull `reset_n_i` low between edges while issuing → `v_o` drops immediately, before the next edge.
  - After release there is no residual issue.

Source files
------------

// File: rtl/bsg_priority_issue_queue_pkg.sv
// Shared helpers for the priority issue queue slice.
package bsg_priority_issue_queue_pkg;

    // Index width for a request vector; never narrower than one bit.
    function automatic int unsigned lg_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bsg_priority_issue_queue_encode.sv
// Priority encoder over the pending mask, plus the binary-to-one-hot decoder
// used to retire the selected bit.
module bsg_priority_encode
    import bsg_priority_issue_queue_pkg::*;
#(
    parameter int unsigned width_p    = 32,
    parameter bit          lo_to_hi_p = 1'b0,
    localparam int unsigned lg_width_lp = lg_width(width_p)
) (
    input  logic [width_p-1:0]     i,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o
);

    logic found;

    // Ascending scan: the last hit wins for high-index priority, the first
    // hit wins (and locks) for low-index priority.
    always_comb begin
        addr_o = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < width_p; k++) begin
            if (i[k] && !(lo_to_hi_p && found)) begin
                addr_o = lg_width_lp'(k);
                found  = 1'b1;
            end
        end
        v_o = |i;
    end

endmodule

module bsg_decode
    import bsg_priority_issue_queue_pkg::*;
#(
    parameter int unsigned num_out_p = 32,
    localparam int unsigned lg_width_lp = lg_width(num_out_p)
) (
    input  logic [lg_width_lp-1:0] i,
    output logic [num_out_p-1:0]   o
);

    always_comb begin
        o = '0;
        for (int unsigned k = 0; k < num_out_p; k++) begin
            o[k] = (i == lg_width_lp'(k));
        end
    end

endmodule

// File: rtl/bsg_priority_issue_queue.sv
// Pending-request bitmask that priority-issues one registered index at a time
// on a valid/yumi interface, retiring each bit when it is loaded.
module bsg_priority_issue_queue
    import bsg_priority_issue_queue_pkg::*;
#(
    parameter int unsigned width_p    = 32,
    parameter bit          lo_to_hi_p = 1'b0,
    localparam int unsigned lg_width_lp = lg_width(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   set_v_i,
    input  logic [width_p-1:0]     set_i,
    input  logic                   clr_all_i,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] addr_o,
    input  logic                   yumi_i,
    output logic [width_p-1:0]     pending_o,
    output logic                   empty_o
);

    logic [width_p-1:0]     pending_r;
    logic                   v_r;
    logic [lg_width_lp-1:0] addr_r;
    logic [lg_width_lp-1:0] sel_addr;
    logic [width_p-1:0]     sel_oh;
    logic                   sel_v;
    logic                   load;

    bsg_priority_encode #(
        .width_p    (width_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) encode (
        .i      (pending_r),
        .addr_o (sel_addr),
        .v_o    (sel_v)
    );

    bsg_decode #(
        .num_out_p (width_p)
    ) decode (
        .i (sel_addr),
        .o (sel_oh)
    );

    assign load = (~v_r | yumi_i) & sel_v & ~clr_all_i;

    // Clearing the loaded bit and OR-ing new sets in the same cycle lets a
    // set of the in-flight/loading index re-arm it as a fresh event.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_r <= '0;
            v_r       <= 1'b0;
            addr_r    <= '0;
        end else if (clr_all_i) begin
            pending_r <= '0;
            v_r       <= 1'b0;
        end else begin
            pending_r <= (pending_r & ~(load ? sel_oh : '0)) | (set_v_i ? set_i : '0);
            if (load) begin
                v_r    <= 1'b1;
                addr_r <= sel_addr;
            end else if (yumi_i) begin
                v_r <= 1'b0;
            end
        end
    end

    assign v_o       = v_r;
    assign addr_o    = addr_r;
    assign pending_o = pending_r;
    assign empty_o   = ~v_r & ~|pending_r;

`ifndef SYNTHESIS
    yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_r))
        else $error("yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_priority_issue_queue.sv
// Directed bench for bsg_priority_issue_queue: one instance per priority direction.
module tb_bsg_priority_issue_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        set_v;
    logic [31:0] set;
    logic        clr_all;
    logic        auto_yumi;
    logic        yumi_man;

    logic        v0, v1, yumi0, yumi1, empty0, empty1;
    logic [4:0]  addr0, addr1;
    logic [31:0] pending0, pending1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    // Consumer only ever yumis a valid index, so the protocol stays legal.
    assign yumi0 = v0 & (auto_yumi | yumi_man);
    assign yumi1 = v1 & (auto_yumi | yumi_man);

    bsg_priority_issue_queue #(
        .width_p    (32),
        .lo_to_hi_p (1'b0)
    ) dut_hi (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .set_v_i   (set_v),
        .set_i     (set),
        .clr_all_i (clr_all),
        .v_o       (v0),
        .addr_o    (addr0),
        .yumi_i    (yumi0),
        .pending_o (pending0),
        .empty_o   (empty0)
    );

    bsg_priority_issue_queue #(
        .width_p    (32),
        .lo_to_hi_p (1'b1)
    ) dut_lo (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .set_v_i   (set_v),
        .set_i     (set),
        .clr_all_i (clr_all),
        .v_o       (v1),
        .addr_o    (addr1),
        .yumi_i    (yumi1),
        .pending_o (pending1),
        .empty_o   (empty1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        set_v     = 1'b0;
        set       = '0;
        clr_all   = 1'b0;
        auto_yumi = 1'b0;
        yumi_man  = 1'b0;

        // Reset / idle
        repeat (3) tick();
        check_eq("rst_v",       v0,       0);
        check_eq("rst_addr",    addr0,    0);
        check_eq("rst_pending", pending0, 0);
        check_eq("rst_empty",   empty0,   1);
        reset_n = 1'b1;
        repeat (2) tick();
        check_eq("idle_v",     v0,     0);
        check_eq("idle_empty", empty0, 1);

        // Priority drain, both directions
        auto_yumi = 1'b1;
        set_v = 1'b1; set = 32'h8000_0011;
        tick();
        set_v = 1'b0; set = '0;
        check_eq("drain_pending_n1", pending0, 32'h8000_0011);
        check_eq("drain_v_n1",       v0,       0);
        tick();
        check_eq("drain_hi_0", addr0, 31);
        check_eq("drain_lo_0", addr1, 0);
        check_eq("drain_v_0",  v0,    1);
        tick();
        check_eq("drain_hi_1", addr0, 4);
        check_eq("drain_lo_1", addr1, 4);
        tick();
        check_eq("drain_hi_2", addr0, 0);
        check_eq("drain_lo_2", addr1, 31);
        tick();
        check_eq("drain_hi_done", v0,     0);
        check_eq("drain_lo_done", v1,     0);
        check_eq("drain_empty",   empty0, 1);
        auto_yumi = 1'b0;

        // Backpressure
        set_v = 1'b1; set = 32'h0000_0006;
        tick();
        set_v = 1'b0;
        tick();
        check_eq("bp_v",       v0,       1);
        check_eq("bp_addr",    addr0,    2);
        check_eq("bp_pending", pending0, 32'h0000_0002);
        set_v = 1'b1; set = 32'h0000_0100;
        tick();
        set_v = 1'b0;
        check_eq("bp_pending_acc", pending0, 32'h0000_0102);
        check_eq("bp_addr_held",   addr0,    2);
        tick();
        check_eq("bp_addr_held2", addr0, 2);
        yumi_man = 1'b1;
        tick();
        check_eq("bp_next_addr",    addr0,    8);
        check_eq("bp_next_pending", pending0, 32'h0000_0002);
        tick();
        check_eq("bp_last_addr", addr0, 1);
        tick();
        check_eq("bp_drained", empty0, 1);
        yumi_man = 1'b0;

        // Re-arm of the in-flight index
        set_v = 1'b1; set = 32'h0000_0020;
        tick();
        set_v = 1'b0;
        tick();
        check_eq("rearm_addr",    addr0,    5);
        check_eq("rearm_pending", pending0, 0);
        set_v = 1'b1;
        tick();
        set_v = 1'b0;
        check_eq("rearm_pending_set", pending0, 32'h0000_0020);
        check_eq("rearm_addr_held",   addr0,    5);
        yumi_man = 1'b1;
        tick();
        check_eq("rearm_reissue_v",    v0,       1);
        check_eq("rearm_reissue_addr", addr0,    5);
        check_eq("rearm_reissue_pend", pending0, 0);
        tick();
        check_eq("rearm_done_v", v0, 0);
        yumi_man = 1'b0;

        // Flush
        set_v = 1'b1; set = 32'h0001_FF00;
        tick();
        set_v = 1'b0;
        tick();
        check_eq("flush_pre_addr",    addr0,    16);
        check_eq("flush_pre_pending", pending0, 32'h0000_FF00);
        clr_all = 1'b1; set_v = 1'b1; set = 32'h0000_0001;
        tick();
        clr_all = 1'b0; set_v = 1'b0; set = '0;
        check_eq("flush_v",       v0,       0);
        check_eq("flush_pending", pending0, 0);
        check_eq("flush_empty",   empty0,   1);
        tick();
        check_eq("flush_stays_empty", empty0, 1);

        // Asynchronous reset mid-stream
        auto_yumi = 1'b1;
        set_v = 1'b1; set = 32'h0000_0007;
        tick();
        set_v = 1'b0; set = '0;
        tick();
        check_eq("arst_pre_v",    v0,    1);
        check_eq("arst_pre_addr", addr0, 2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_v_now",       v0,       0);
        check_eq("arst_addr_now",    addr0,    0);
        check_eq("arst_pending_now", pending0, 0);
        check_eq("arst_empty_now",   empty0,   1);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_eq("arst_post_v",     v0,     0);
        check_eq("arst_post_empty", empty0, 1);
        check_eq("arst_post_v_lo",  v1,     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
